// File: rtl/rotary_counter.sv
// rtl/rotary_counter.sv - debounced quadrature decoder driving a wrapping 4-bit up/down count
//
// Ports:
//   clk      system clock, all state on rising edge
//   rst_n    asynchronous active-low reset
//   enc_a    encoder channel A (asynchronous)
//   enc_b    encoder channel B (asynchronous)
//   btn      push-button, active-high (asynchronous); rising edge clears the count
//   counter  current count 0..15
//   step     one-cycle pulse when counter moves due to rotation
//   dir      direction of the last step, 1 = up (CW)
//   err      sticky illegal-transition flag, cleared by the button
module rotary_counter #(
  parameter int DB_CYCLES  = 4,
  parameter int DETENT_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enc_a,
  input  logic       enc_b,
  input  logic       btn,
  output logic [3:0] counter,
  output logic       step,
  output logic       dir,
  output logic       err
);

  localparam logic [3:0]        DBC_LAST    = 4'(DB_CYCLES - 1);
  localparam logic [4:0]        SETTLE_LAST = 5'(DB_CYCLES + 2);
  localparam logic signed [2:0] ACC_MAX     = 3'(DETENT_DIV - 1);
  localparam logic signed [2:0] ACC_MIN     = -ACC_MAX;

  // Channel index: 0 = enc_a, 1 = enc_b, 2 = btn.
  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       filt_q, filt_d;
  logic [2:0][3:0]  dbc_q, dbc_d;
  logic [4:0]       settle_q, settle_d;
  logic             armed_q, armed_d;
  logic [1:0]       prev_q, prev_d;
  logic             btn_prev_q, btn_prev_d;
  logic signed [2:0] acc_q, acc_d;
  logic [3:0]       counter_q, counter_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic [1:0] cur;
  logic [1:0] pos_cur;
  logic [1:0] pos_prev;
  logic [1:0] delta;
  logic       clr;

  always_comb begin
    sync1_d = {btn, enc_b, enc_a};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    dbc_d   = dbc_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        dbc_d[i] = 4'd0;
      end else if (dbc_q[i] == DBC_LAST) begin
        filt_d[i] = sync2_q[i];
        dbc_d[i]  = 4'd0;
      end else begin
        dbc_d[i] = dbc_q[i] + 4'd1;
      end
    end
  end

  // The settle window outlasts the sync + debounce latency so prev has
  // captured the real pin state before the first comparison is made.
  always_comb begin
    settle_d = settle_q;
    armed_d  = armed_q;
    if (!armed_q) begin
      if (settle_q == SETTLE_LAST) begin
        armed_d = 1'b1;
      end else begin
        settle_d = settle_q + 5'd1;
      end
    end
  end

  always_comb begin
    // Gray -> binary position: 00,01,11,10 -> 0,1,2,3, so CW is +1 mod 4.
    cur      = {filt_q[0], filt_q[1]};
    pos_cur  = {cur[1], cur[1] ^ cur[0]};
    pos_prev = {prev_q[1], prev_q[1] ^ prev_q[0]};
    delta    = pos_cur - pos_prev;
    clr      = filt_q[2] & ~btn_prev_q;

    prev_d     = cur;
    btn_prev_d = filt_q[2];
    counter_d  = counter_q;
    acc_d      = acc_q;
    step_d     = 1'b0;
    dir_d      = dir_q;
    err_d      = err_q;

    // Clear wins over anything decoded in the same cycle.
    if (clr) begin
      counter_d = 4'd0;
      acc_d     = 3'sd0;
      err_d     = 1'b0;
    end else if (armed_q) begin
      case (delta)
        2'd1: begin
          if (acc_q == ACC_MAX) begin
            counter_d = counter_q + 4'd1;
            acc_d     = 3'sd0;
            step_d    = 1'b1;
            dir_d     = 1'b1;
          end else begin
            acc_d = acc_q + 3'sd1;
          end
        end
        2'd3: begin
          if (acc_q == ACC_MIN) begin
            counter_d = counter_q - 4'd1;
            acc_d     = 3'sd0;
            step_d    = 1'b1;
            dir_d     = 1'b0;
          end else begin
            acc_d = acc_q - 3'sd1;
          end
        end
        2'd2: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      dbc_q      <= '0;
      settle_q   <= '0;
      armed_q    <= 1'b0;
      prev_q     <= '0;
      btn_prev_q <= 1'b0;
      acc_q      <= 3'sd0;
      counter_q  <= 4'd0;
      step_q     <= 1'b0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      filt_q     <= filt_d;
      dbc_q      <= dbc_d;
      settle_q   <= settle_d;
      armed_q    <= armed_d;
      prev_q     <= prev_d;
      btn_prev_q <= btn_prev_d;
      acc_q      <= acc_d;
      counter_q  <= counter_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
    end
  end

  assign counter = counter_q;
  assign step    = step_q;
  assign dir     = dir_q;
  assign err     = err_q;

endmodule

// File: tb/tb_rotary_counter.sv
// tb/tb_rotary_counter.sv - scoreboard bench for rotary_counter
module tb_rotary_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enc_a;
  logic       enc_b;
  logic       btn;
  logic [3:0] counter;
  logic       step;
  logic       dir;
  logic       err;

  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] exp_q [$];
  logic [4:0] mon_exp;
  logic [3:0] exp_cnt = 4'd0;

  rotary_counter #(.DB_CYCLES(4), .DETENT_DIV(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .btn     (btn),
    .counter (counter),
    .step    (step),
    .dir     (dir),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Every step pulse must match the oldest expected {dir, counter}.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && step === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL step_unexpected: got step=1 counter=%0d dir=%0d, required no step", counter, dir);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({dir, counter} !== mon_exp) begin
            n_err++;
            $display("FAIL step_value: got dir=%0d counter=%0d, required dir=%0d counter=%0d",
                     dir, counter, mon_exp[4], mon_exp[3:0]);
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pins(input logic a, input logic b, input int n);
    @(negedge clk);
    enc_a = a;
    enc_b = b;
    wait_cyc(n);
  endtask

  task automatic expect_step(input logic d);
    if (d) exp_cnt = exp_cnt + 4'd1;
    else   exp_cnt = exp_cnt - 4'd1;
    exp_q.push_back({d, exp_cnt});
  endtask

  task automatic cw_detent();
    set_pins(1'b0, 1'b1, 20);
    set_pins(1'b1, 1'b1, 20);
    set_pins(1'b1, 1'b0, 20);
    expect_step(1'b1);
    set_pins(1'b0, 1'b0, 20);
  endtask

  task automatic ccw_detent();
    set_pins(1'b1, 1'b0, 20);
    set_pins(1'b1, 1'b1, 20);
    set_pins(1'b0, 1'b1, 20);
    expect_step(1'b0);
    set_pins(1'b0, 1'b0, 20);
  endtask

  task automatic press_btn();
    @(negedge clk);
    btn = 1'b1;
    wait_cyc(12);
    btn = 1'b0;
    wait_cyc(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enc_a = 1'b1;
    enc_b = 1'b1;
    btn   = 1'b0;
    wait_cyc(4);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL reset_counter: got %0d, required 0", counter); end
    n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL reset_step: got %0d, required 0", step); end
    n_vec++; if (dir !== 1'b1) begin n_err++; $display("FAIL reset_dir: got %0d, required 1", dir); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0d, required 0", err); end
    wait_cyc(30);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL arm_err: got %0d, required 0", err); end
    n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL arm_counter: got %0d, required 0", counter); end
  endtask

  task automatic test_cw_detent();
    int lat;
    bit seen;
    // Half a detent, then reset: the partial sub-count must be discarded.
    set_pins(1'b1, 1'b0, 20);
    set_pins(1'b0, 1'b0, 20);
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    set_pins(1'b0, 1'b1, 20);
    set_pins(1'b1, 1'b1, 20);
    set_pins(1'b1, 1'b0, 20);
    expect_step(1'b1);
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 15 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (step === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    // The first posedge after the pin change is the sampling edge k; k+6 is the 7th.
    n_vec++; if (lat != 7) begin n_err++; $display("FAIL cw_latency: got %0d edges, required 7", lat); end
    wait_cyc(15);
    n_vec++; if (counter !== 4'd1) begin n_err++; $display("FAIL cw_counter: got %0d, required 1", counter); end
    n_vec++; if (dir !== 1'b1) begin n_err++; $display("FAIL cw_dir: got %0d, required 1", dir); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL cw_err: got %0d, required 0", err); end
  endtask

  task automatic test_wrap();
    press_btn();
    exp_cnt = 4'd0;
    n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL wrap_clear: got %0d, required 0", counter); end
    ccw_detent();
    n_vec++; if (counter !== 4'd15) begin n_err++; $display("FAIL wrap_down: got %0d, required 15", counter); end
    n_vec++; if (dir !== 1'b0) begin n_err++; $display("FAIL wrap_down_dir: got %0d, required 0", dir); end
    cw_detent();
    n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL wrap_up: got %0d, required 0", counter); end
    n_vec++; if (dir !== 1'b1) begin n_err++; $display("FAIL wrap_up_dir: got %0d, required 1", dir); end
  endtask

  task automatic test_bounce();
    set_pins(1'b0, 1'b1, 20);
    @(negedge clk); enc_a = 1'b1; wait_cyc(3); enc_a = 1'b0; wait_cyc(20);
    set_pins(1'b1, 1'b1, 20);
    set_pins(1'b1, 1'b0, 20);
    // A at 10 with a full sub-count: an accepted glitch here would step early.
    @(negedge clk); enc_a = 1'b0; wait_cyc(3); enc_a = 1'b1; wait_cyc(20);
    n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL bounce_counter: got %0d, required 0", counter); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL bounce_err: got %0d, required 0", err); end
    // A 4-cycle pulse is long enough: 10->00 steps, 00->10 backs off, 10->00 returns to zero.
    expect_step(1'b1);
    @(negedge clk); enc_a = 1'b0; wait_cyc(4); enc_a = 1'b1; wait_cyc(20);
    set_pins(1'b0, 1'b0, 20);
    n_vec++; if (counter !== 4'd1) begin n_err++; $display("FAIL pulse4_counter: got %0d, required 1", counter); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL pulse4_err: got %0d, required 0", err); end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL pulse4_pending: got %0d pending steps, required 0", exp_q.size()); end
  endtask

  task automatic test_illegal();
    set_pins(1'b1, 1'b1, 20);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err: got %0d, required 1", err); end
    n_vec++; if (counter !== 4'd1) begin n_err++; $display("FAIL illegal_counter: got %0d, required 1", counter); end
    set_pins(1'b0, 1'b0, 20);
    press_btn();
    exp_cnt = 4'd0;
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL illegal_clear_err: got %0d, required 0", err); end
    n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL illegal_clear_counter: got %0d, required 0", counter); end
  endtask

  task automatic test_clear_vs_step();
    cw_detent();
    n_vec++; if (counter !== 4'd1) begin n_err++; $display("FAIL cvs_pre: got %0d, required 1", counter); end
    set_pins(1'b0, 1'b1, 20);
    set_pins(1'b1, 1'b1, 20);
    set_pins(1'b1, 1'b0, 20);
    // Button and final edge share the same sync/debounce latency, so they collide.
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b0;
    btn   = 1'b1;
    wait_cyc(20);
    exp_cnt = 4'd0;
    n_vec++; if (counter !== 4'd0) begin n_err++; $display("FAIL cvs_counter: got %0d, required 0", counter); end
    n_vec++; if (step !== 1'b0) begin n_err++; $display("FAIL cvs_step: got %0d, required 0", step); end
    // Button still held: no re-clear, and a zeroed sub-count needs a full detent.
    cw_detent();
    n_vec++; if (counter !== 4'd1) begin n_err++; $display("FAIL cvs_after: got %0d, required 1", counter); end
    @(negedge clk);
    btn = 1'b0;
    wait_cyc(20);
  endtask

  initial begin
    test_reset();
    test_cw_detent();
    test_wrap();
    test_bounce();
    test_illegal();
    test_clear_vs_step();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_pending: got %0d pending steps, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
